vdp_cpu_bridge: RTL and testbench
=================================

VDP_CPU_BRIDGE -- requirements
Module: vdp_cpu_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer flop count for csr_n_i/csw_n_i (legal 2..4).
REQ-002 SHALL have parameter RELEASE_CYCLES, default 3, giving the consecutive both-deasserted cycles needed to end an access (legal 1..15).
REQ-003 SHALL have port clk_w  input  1  VDP pixel-domain clock (27 MHz); all state is on its rising edge.
REQ-004 SHALL have port reset_n_w  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port csr_n_i  input  1  filtered host read strobe, asynchronous to clk_w, active-low.
REQ-006 SHALL have port csw_n_i  input  1  filtered host write strobe, asynchronous to clk_w, active-low.
REQ-007 SHALL have port mode_i  input  2  host port select (MODE1, MODE0).
REQ-008 SHALL have port cd_i  input  8  host data bus, input side.
REQ-009 SHALL have port vdp_dbi_i  input  8  VDP read data (VDP DBI).
REQ-010 SHALL have port req_o  output  1  one-cycle access request to the VDP.
REQ-011 SHALL have port wrt_o  output  1  write qualifier, valid only while req_o=1.
REQ-012 SHALL have port adr_o  output  16  {14'b0, captured mode}.
REQ-013 SHALL have port dbo_o  output  8  captured write data.
REQ-014 SHALL have port rd_data_o  output  8  latched read data for the host bus.
REQ-015 SHALL have port cd_oe_o  output  1  host bus drive enable = ~csr_n_i, combinational from the raw pin.
REQ-016 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-017 SHALL have port err_o  output  1  one-cycle pulse on detection of simultaneous read and write strobes.

Function
REQ-018 SHALL pass csr_n_i and csw_n_i through SYNC_STAGES flops each; "rd" and "wr" mean the last-stage values inverted.
REQ-019 SHALL implement the states IDLE, ISSUE, CAPTURE, RELEASE and CONFLICT.
REQ-020 IDLE: rd XOR wr -> register mode_i into adr_o[1:0], cd_i into dbo_o and wr into a write flag, then enter ISSUE on the same edge.
REQ-021 IDLE: rd AND wr -> pulse err_o for one cycle, issue no request, enter CONFLICT.
REQ-022 ISSUE: assert req_o=1 for exactly one cycle with wrt_o=write flag; go to CAPTURE on a read and to RELEASE on a write.
REQ-023 CAPTURE: register vdp_dbi_i into rd_data_o one cycle after req_o, then go to RELEASE; latency from the first synchronized strobe to req_o is 1 cycle.
REQ-024 RELEASE: count cycles with rd=0 and wr=0; any asserted strobe clears the count; return to IDLE when the count reaches RELEASE_CYCLES.
REQ-025 A strobe-pattern change inside RELEASE (e.g. read changing to write with no release) SHALL NOT start a new access; exactly one req_o per host access.
REQ-026 CONFLICT: same release rule as RELEASE, then IDLE; err_o is not re-pulsed while in CONFLICT.
REQ-027 rd_data_o SHALL hold its value until the next CAPTURE; dbo_o and adr_o SHALL hold until the next capture in IDLE.
REQ-028 wrt_o SHALL be 0 whenever req_o=0.
REQ-029 The release counter SHALL saturate and never wrap.

Reset
REQ-030 While reset_n_w=0: synchronizers=1 (deasserted), state=IDLE, counter=0, and req_o, wrt_o, busy_o, err_o, adr_o, dbo_o, rd_data_o all 0.
REQ-031 Reset deassertion with a strobe already low SHALL start a normal access after the synchronizer latency; reset mid-access SHALL abort with no further req_o.

Verification
REQ-032 Write: mode_i=2'b01, cd_i=8'hA5, csw_n_i low for 20 cycles -> exactly one req_o, wrt_o=1, adr_o=16'h0001, dbo_o=8'hA5, issued SYNC_STAGES+1 cycles after the falling edge.
REQ-033 Read: vdp_dbi_i=8'h3C, csr_n_i low for 20 cycles -> one req_o with wrt_o=0; rd_data_o=8'h3C on the following cycle; cd_oe_o follows csr_n_i with no delay.
REQ-034 Conflict: csr_n_i and csw_n_i both low together -> err_o one pulse, no req_o; after 3 release cycles a write access is accepted normally.
REQ-035 Release glitch: csw_n_i high for 2 cycles, low again, then high -> no second req_o; busy_o falls 3 cycles after the final release.
REQ-036 Back-to-back: write, 3-cycle release, read -> two req_o pulses, wrt_o 1 then 0.
REQ-037 Reset mid-access: reset_n_w asserted in CAPTURE -> all outputs 0 immediately; no req_o until a new strobe follows reset deassertion.

Source files
------------

// File: rtl/vdp_cpu_bridge.sv
// Host CPU strobe bridge for the VDP. It synchronizes the host read and write strobes and
// turns each host access into exactly one VDP request.
module vdp_cpu_bridge #(
  parameter int SYNC_STAGES    = 2,
  parameter int RELEASE_CYCLES = 3
) (
  input  logic        clk_w,
  input  logic        reset_n_w,
  input  logic        csr_n_i,
  input  logic        csw_n_i,
  input  logic [1:0]  mode_i,
  input  logic [7:0]  cd_i,
  input  logic [7:0]  vdp_dbi_i,
  output logic        req_o,
  output logic        wrt_o,
  output logic [15:0] adr_o,
  output logic [7:0]  dbo_o,
  output logic [7:0]  rd_data_o,
  output logic        cd_oe_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] REL_MAX = CNT_W'(RELEASE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RELEASE,
    ST_CONFLICT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [SYNC_STAGES-1:0] csr_sync_q, csw_sync_q;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       dbo_q, dbo_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             wr_flag_q, wr_flag_d;
  logic             err_q, err_d;
  logic             rd, wr;

  // Both chains reset to 1 so that a strobe seen during reset looks like a fresh falling edge.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      csr_sync_q <= '1;
      csw_sync_q <= '1;
    end else begin
      csr_sync_q <= {csr_sync_q[SYNC_STAGES-2:0], csr_n_i};
      csw_sync_q <= {csw_sync_q[SYNC_STAGES-2:0], csw_n_i};
    end
  end

  assign rd = ~csr_sync_q[SYNC_STAGES-1];
  assign wr = ~csw_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      dbo_q     <= '0;
      rd_data_q <= '0;
      wr_flag_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      dbo_q     <= dbo_d;
      rd_data_q <= rd_data_d;
      wr_flag_q <= wr_flag_d;
      err_q     <= err_d;
    end
  end

  assign cnt_inc = (cnt_q == REL_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    dbo_d     = dbo_q;
    rd_data_d = rd_data_q;
    wr_flag_d = wr_flag_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rd && wr) begin
          err_d   = 1'b1;
          state_d = ST_CONFLICT;
        end else if (rd ^ wr) begin
          mode_d    = mode_i;
          dbo_d     = cd_i;
          wr_flag_d = wr;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = wr_flag_q ? ST_RELEASE : ST_CAPTURE;
      ST_CAPTURE: begin
        rd_data_d = vdp_dbi_i;
        state_d   = ST_RELEASE;
      end
      ST_RELEASE, ST_CONFLICT: begin
        // Any strobe activity restarts the quiet-time count, so a glitchy release never re-triggers.
        if (rd || wr) begin
          cnt_d = '0;
        end else if (cnt_inc == REL_MAX) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_o     = (state_q == ST_ISSUE);
  assign wrt_o     = req_o & wr_flag_q;
  assign adr_o     = {14'b0, mode_q};
  assign dbo_o     = dbo_q;
  assign rd_data_o = rd_data_q;
  assign cd_oe_o   = ~csr_n_i;
  assign busy_o    = (state_q != ST_IDLE);
  assign err_o     = err_q;

endmodule

// File: tb/tb_vdp_cpu_bridge.sv
// Directed bench for vdp_cpu_bridge: drives inputs on the falling edge and samples outputs there.
module tb_vdp_cpu_bridge;

  logic        clk_w = 1'b0;
  logic        reset_n_w;
  logic        csr_n_i, csw_n_i;
  logic [1:0]  mode_i;
  logic [7:0]  cd_i, vdp_dbi_i;
  logic        req_o, wrt_o, cd_oe_o, busy_o, err_o;
  logic [15:0] adr_o;
  logic [7:0]  dbo_o, rd_data_o;

  int checks = 0;
  int errors = 0;
  int req_count = 0;
  int err_count = 0;
  int wrt_viol = 0;
  logic wrt_hist[$];

  vdp_cpu_bridge #(.SYNC_STAGES(2), .RELEASE_CYCLES(3)) dut (
    .clk_w(clk_w), .reset_n_w(reset_n_w), .csr_n_i(csr_n_i), .csw_n_i(csw_n_i),
    .mode_i(mode_i), .cd_i(cd_i), .vdp_dbi_i(vdp_dbi_i), .req_o(req_o), .wrt_o(wrt_o),
    .adr_o(adr_o), .dbo_o(dbo_o), .rd_data_o(rd_data_o), .cd_oe_o(cd_oe_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_w = ~clk_w;

  always @(negedge clk_w) begin
    if (req_o) begin
      req_count++;
      wrt_hist.push_back(wrt_o);
    end
    if (err_o) err_count++;
    if (!req_o && wrt_o) wrt_viol++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_w);
  endtask

  task automatic test_reset();
    reset_n_w = 1'b0; csr_n_i = 1'b1; csw_n_i = 1'b1;
    mode_i = 2'b00; cd_i = 8'h00; vdp_dbi_i = 8'h00;
    tick(3);
    checks++;
    if ({req_o, wrt_o, busy_o, err_o, cd_oe_o} !== 5'b0 || adr_o !== 16'h0 || dbo_o !== 8'h0 || rd_data_o !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b wrt=%b busy=%b err=%b oe=%b adr=%h dbo=%h rd=%h want all 0",
               req_o, wrt_o, busy_o, err_o, cd_oe_o, adr_o, dbo_o, rd_data_o);
    end
    reset_n_w = 1'b1;
    tick(3);
    $display("reset: outputs idle");
  endtask

  task automatic test_write();
    int base;
    base = req_count;
    mode_i = 2'b01; cd_i = 8'hA5;
    csw_n_i = 1'b0;
    tick(2);
    checks++;
    if (req_o !== 1'b0) begin errors++; $display("FAIL write_early_req got %b want 0", req_o); end
    tick(1);
    checks++;
    if (req_o !== 1'b1 || wrt_o !== 1'b1) begin
      errors++; $display("FAIL write_req got req=%b wrt=%b want req=1 wrt=1", req_o, wrt_o);
    end
    checks++;
    if (adr_o !== 16'h0001 || dbo_o !== 8'hA5) begin
      errors++; $display("FAIL write_data got adr=%h dbo=%h want adr=0001 dbo=a5", adr_o, dbo_o);
    end
    cd_i = 8'h00; mode_i = 2'b00;
    tick(17);
    csw_n_i = 1'b1;
    tick(8);
    checks++;
    if (req_count - base !== 1) begin errors++; $display("FAIL write_req_count got %0d want 1", req_count - base); end
    checks++;
    if (adr_o !== 16'h0001 || dbo_o !== 8'hA5 || busy_o !== 1'b0) begin
      errors++; $display("FAIL write_hold got adr=%h dbo=%h busy=%b want adr=0001 dbo=a5 busy=0", adr_o, dbo_o, busy_o);
    end
    $display("write: mode=01 data=a5");
  endtask

  task automatic test_read();
    int base;
    base = req_count;
    vdp_dbi_i = 8'h3C;
    csr_n_i = 1'b0;
    #1;
    checks++;
    if (cd_oe_o !== 1'b1) begin errors++; $display("FAIL read_oe_on got %b want 1", cd_oe_o); end
    tick(3);
    checks++;
    if (req_o !== 1'b1 || wrt_o !== 1'b0) begin
      errors++; $display("FAIL read_req got req=%b wrt=%b want req=1 wrt=0", req_o, wrt_o);
    end
    tick(2);
    checks++;
    if (rd_data_o !== 8'h3C) begin errors++; $display("FAIL read_data got %h want 3c", rd_data_o); end
    vdp_dbi_i = 8'h77;
    tick(15);
    csr_n_i = 1'b1;
    #1;
    checks++;
    if (cd_oe_o !== 1'b0) begin errors++; $display("FAIL read_oe_off got %b want 0", cd_oe_o); end
    tick(8);
    checks++;
    if (req_count - base !== 1 || rd_data_o !== 8'h3C) begin
      errors++; $display("FAIL read_hold got reqs=%0d rd=%h want reqs=1 rd=3c", req_count - base, rd_data_o);
    end
    $display("read: data=3c");
  endtask

  task automatic test_conflict();
    int base_r, base_e;
    base_r = req_count; base_e = err_count;
    csr_n_i = 1'b0; csw_n_i = 1'b0;
    tick(3);
    checks++;
    if (err_o !== 1'b1 || req_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL conflict_err got err=%b req=%b busy=%b want err=1 req=0 busy=1", err_o, req_o, busy_o);
    end
    tick(1);
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL conflict_pulse got %b want 0", err_o); end
    tick(10);
    csr_n_i = 1'b1; csw_n_i = 1'b1;
    tick(4);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL conflict_busy got %b want 1", busy_o); end
    tick(1);
    checks++;
    if (busy_o !== 1'b0 || req_count != base_r || err_count - base_e !== 1) begin
      errors++; $display("FAIL conflict_end got busy=%b reqs=%0d errs=%0d want busy=0 reqs=0 errs=1",
                         busy_o, req_count - base_r, err_count - base_e);
    end
    mode_i = 2'b10; cd_i = 8'h5A;
    csw_n_i = 1'b0;
    tick(3);
    checks++;
    if (req_o !== 1'b1 || wrt_o !== 1'b1 || adr_o !== 16'h0002 || dbo_o !== 8'h5A) begin
      errors++; $display("FAIL conflict_recover got req=%b wrt=%b adr=%h dbo=%h want 1 1 0002 5a", req_o, wrt_o, adr_o, dbo_o);
    end
    tick(3);
    csw_n_i = 1'b1;
    tick(8);
    $display("conflict: one err pulse, write accepted after release");
  endtask

  task automatic test_glitch();
    int base;
    base = req_count;
    mode_i = 2'b11; cd_i = 8'h0F;
    csw_n_i = 1'b0;
    tick(10);
    csw_n_i = 1'b1;
    tick(2);
    csw_n_i = 1'b0;
    tick(5);
    csw_n_i = 1'b1;
    tick(4);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy_hold got %b want 1", busy_o); end
    tick(1);
    checks++;
    if (busy_o !== 1'b0 || req_count - base !== 1) begin
      errors++; $display("FAIL glitch_end got busy=%b reqs=%0d want busy=0 reqs=1", busy_o, req_count - base);
    end
    $display("glitch: single request across release glitch");
  endtask

  task automatic test_back_to_back();
    wrt_hist.delete();
    mode_i = 2'b00; cd_i = 8'hC3; vdp_dbi_i = 8'h99;
    csw_n_i = 1'b0;
    tick(5);
    csw_n_i = 1'b1;
    tick(5);
    csr_n_i = 1'b0;
    tick(6);
    csr_n_i = 1'b1;
    tick(8);
    checks++;
    if (wrt_hist.size() !== 2) begin
      errors++; $display("FAIL b2b_count got %0d want 2", wrt_hist.size());
    end else begin
      checks++;
      if (wrt_hist[0] !== 1'b1 || wrt_hist[1] !== 1'b0) begin
        errors++; $display("FAIL b2b_wrt got %b%b want 10", wrt_hist[0], wrt_hist[1]);
      end
    end
    checks++;
    if (rd_data_o !== 8'h99) begin errors++; $display("FAIL b2b_rdata got %h want 99", rd_data_o); end
    $display("back_to_back: write then read");
  endtask

  task automatic test_reset_mid();
    int base;
    vdp_dbi_i = 8'hE1;
    csr_n_i = 1'b0;
    tick(4);
    reset_n_w = 1'b0;
    #1;
    checks++;
    if ({req_o, wrt_o, busy_o, err_o} !== 4'b0 || adr_o !== 16'h0 || dbo_o !== 8'h0 || rd_data_o !== 8'h0) begin
      errors++; $display("FAIL reset_mid got req=%b wrt=%b busy=%b err=%b adr=%h dbo=%h rd=%h want all 0",
                         req_o, wrt_o, busy_o, err_o, adr_o, dbo_o, rd_data_o);
    end
    base = req_count;
    tick(1);
    csr_n_i = 1'b1;
    tick(2);
    reset_n_w = 1'b1;
    tick(10);
    checks++;
    if (req_count != base || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_quiet got reqs=%0d busy=%b want reqs=0 busy=0", req_count - base, busy_o);
    end
    mode_i = 2'b01; cd_i = 8'h42;
    csw_n_i = 1'b0;
    tick(3);
    checks++;
    if (req_o !== 1'b1 || dbo_o !== 8'h42) begin
      errors++; $display("FAIL reset_mid_new got req=%b dbo=%h want req=1 dbo=42", req_o, dbo_o);
    end
    tick(2);
    csw_n_i = 1'b1;
    tick(8);
    $display("reset_mid: access aborted, new access accepted");
  endtask

  task automatic test_reset_strobe_low();
    reset_n_w = 1'b0;
    mode_i = 2'b10; cd_i = 8'h81;
    csw_n_i = 1'b0;
    tick(2);
    reset_n_w = 1'b1;
    tick(2);
    checks++;
    if (req_o !== 1'b0) begin errors++; $display("FAIL rst_low_early got %b want 0", req_o); end
    tick(1);
    checks++;
    if (req_o !== 1'b1 || wrt_o !== 1'b1 || adr_o !== 16'h0002 || dbo_o !== 8'h81) begin
      errors++; $display("FAIL rst_low_req got req=%b wrt=%b adr=%h dbo=%h want 1 1 0002 81", req_o, wrt_o, adr_o, dbo_o);
    end
    tick(2);
    csw_n_i = 1'b1;
    tick(8);
    $display("reset_strobe_low: access after sync latency");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_conflict();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_reset_strobe_low();
    checks++;
    if (wrt_viol !== 0) begin errors++; $display("FAIL wrt_without_req got %0d want 0", wrt_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
